// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the PC fetch controller: FSM states,
// redirect-source encoding, sequential step and target alignment.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RST,
    S_FETCH,
    S_HOLD
  } fetch_state_e;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_BRANCH,
    SRC_JUMP,
    SRC_TRAP
  } redir_src_e;

  localparam int unsigned DEF_INSTR_BYTES = 4;

  // Redirect targets are word aligned: these low bits are cleared and checked.
  localparam int unsigned              ALIGN_BITS     = 2;
  localparam logic [ALIGN_BITS-1:0]    ALIGN_LOW_MASK = '1;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-fetch bus between the PC fetch controller and imem/decode.
// master = controller side, slave = memory/decode side.
interface pc_fetch_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic            instr_valid;
  logic            flush;
  logic            misalign_err;

  modport master (
    output imem_req, imem_addr, instr_valid, flush, misalign_err,
    input  imem_ack
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, flush, misalign_err,
    output imem_ack
  );
endinterface

// File: rtl/pc_fetch_ctrl_redirect_arb.sv
// Combinational next-PC redirect arbiter: trap > jump > branch, word-aligns the
// winner and flags a misaligned target. Trap source exists only with PC_TRAP_EN.
module pc_redirect_arb
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h100)
) (
  input  logic            trap,
  input  logic            jump_en,
  input  logic [XLEN-1:0] jump_target,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            valid,
  output logic [XLEN-1:0] target,
  output logic            misalign
);

  redir_src_e      src;
  logic [XLEN-1:0] raw;

  // Later assignments override earlier ones, so the last test is the highest priority.
  always_comb begin
    src = SRC_NONE;
    raw = '0;
    if (branch_taken) begin
      src = SRC_BRANCH;
      raw = branch_target;
    end
    if (jump_en) begin
      src = SRC_JUMP;
      raw = jump_target;
    end
`ifdef PC_TRAP_EN
    if (trap) begin
      src = SRC_TRAP;
      raw = TRAP_VEC;
    end
`endif
  end

`ifndef PC_TRAP_EN
  logic unused_trap;
  assign unused_trap = trap ^ (^TRAP_VEC);
`endif

  assign valid    = (src != SRC_NONE);
  assign target   = raw & ~{{(XLEN-ALIGN_BITS){1'b0}}, ALIGN_LOW_MASK};
  assign misalign = valid && |(raw[ALIGN_BITS-1:0] & ALIGN_LOW_MASK);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC sequencer and instruction-fetch controller with pending-redirect buffering
// and stale-fetch squash. Optional trap redirect enabled by PC_TRAP_EN.
module pc_fetch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_VEC   = '0,
  parameter logic [XLEN-1:0] TRAP_VEC    = XLEN'(32'h100),
  parameter int unsigned     INSTR_BYTES = DEF_INSTR_BYTES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_cur,
  output logic [XLEN-1:0] pc_in,
  output logic            pc_write,
  input  logic            stall,
  input  logic            jump_en,
  input  logic [XLEN-1:0] jump_target,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            trap,
  pc_fetch_ctrl_if.master fetch
);

  fetch_state_e    state;
  logic            pend_vld;
  logic [XLEN-1:0] pend_tgt;

  logic            redir_vld;
  logic            redir_mis;
  logic [XLEN-1:0] redir_tgt;

  logic            ack;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] flush_tgt;
  logic            instr_valid;
  logic            flush;

  pc_redirect_arb #(
    .XLEN     (XLEN),
    .TRAP_VEC (TRAP_VEC)
  ) u_arb (
    .trap          (trap),
    .jump_en       (jump_en),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .valid         (redir_vld),
    .target        (redir_tgt),
    .misalign      (redir_mis)
  );

  assign ack       = fetch.imem_ack;
  assign seq_pc    = pc_cur + XLEN'(INSTR_BYTES);
  // A redirect arriving on the ack cycle is newer than anything buffered.
  assign flush_tgt = redir_vld ? redir_tgt : pend_tgt;

  always_comb begin
    pc_in       = '0;
    pc_write    = 1'b0;
    flush       = 1'b0;
    instr_valid = 1'b0;
    case (state)
      S_RST: begin
        pc_in    = rst_n ? RESET_VEC : '0;
        pc_write = rst_n;
      end
      S_FETCH: begin
        if (ack) begin
          if (redir_vld || pend_vld) begin
            flush    = 1'b1;
            pc_in    = flush_tgt;
            pc_write = 1'b1;
          end else begin
            instr_valid = 1'b1;
            pc_in       = seq_pc;
            pc_write    = !stall;
          end
        end
      end
      S_HOLD: begin
        if (redir_vld) begin
          flush    = 1'b1;
          pc_in    = redir_tgt;
          pc_write = 1'b1;
        end else begin
          instr_valid = 1'b1;
          pc_in       = seq_pc;
          pc_write    = !stall;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_RST;
      pend_vld <= 1'b0;
      pend_tgt <= '0;
    end else begin
      case (state)
        S_RST: state <= S_FETCH;
        S_FETCH: begin
          if (ack) begin
            pend_vld <= 1'b0;
            if (!redir_vld && !pend_vld && stall) state <= S_HOLD;
          end else if (redir_vld) begin
            pend_vld <= 1'b1;
            pend_tgt <= redir_tgt;
          end
        end
        S_HOLD: begin
          if (redir_vld || !stall) state <= S_FETCH;
        end
        default: state <= S_RST;
      endcase
    end
  end

  assign fetch.imem_req     = (state == S_FETCH);
  assign fetch.imem_addr    = pc_cur;
  assign fetch.instr_valid  = instr_valid;
  assign fetch.flush        = flush;
  assign fetch.misalign_err = redir_mis && (state != S_RST);

endmodule
